// File: rtl/sequence_tx_pkg.sv
// Shared constants for the sequence transmitter and its matching detector.
package sequence_tx_pkg;

    // Default pattern: 5 bits, transmitted MSB first.
    localparam int          DEFAULT_WIDTH = 5;
    localparam logic [4:0]  DEFAULT_CODE  = 5'b10110;

    // FSM state encoding shared by the transmitter and detector.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sequence_tx_counter.sv
// Bit pointer within a frame and remaining-frame counter for one burst.
module sequence_tx_counter
    import sequence_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic [3:0]               load_i,
    input  logic                     step_i,
    output logic [$clog2(WIDTH)-1:0] bit_idx_o,
    output logic                     last_bit_o,
    output logic                     last_frame_o
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic [3:0]    frames_left_q, frames_left_d;

    assign last_bit_o   = (bit_idx_q == LAST_IDX);
    assign last_frame_o = (frames_left_q == 4'd0);
    assign bit_idx_o    = bit_idx_q;

    // Next pointer: clear wins over step; frames wrap with no gap bit.
    always_comb begin
        bit_idx_d     = bit_idx_q;
        frames_left_d = frames_left_q;
        if (clear_i) begin
            bit_idx_d     = '0;
            frames_left_d = load_i;
        end else if (step_i) begin
            if (last_bit_o) begin
                bit_idx_d = '0;
                if (!last_frame_o) begin
                    frames_left_d = frames_left_q - 4'd1;
                end
            end else begin
                bit_idx_d = bit_idx_q + 1'b1;
            end
        end
    end

    // Counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx_q     <= '0;
            frames_left_q <= 4'd0;
        end else begin
            bit_idx_q     <= bit_idx_d;
            frames_left_q <= frames_left_d;
        end
    end

endmodule

// File: rtl/sequence_tx.sv
// Serial pattern transmitter: sends CODE MSB first, repeat_cnt+1 times per
// burst, advancing one bit per en strobe, then pulses done for one cycle.
//
// Handshake: start is accepted only in IDLE (abort has priority); once
// accepted, valid=1 marks y as a pattern bit and each cycle with en=1 consumes
// that bit. All outputs decode from registered state only.
module sequence_tx
    import sequence_tx_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CODE  = WIDTH'(DEFAULT_CODE)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       start,
    input  logic [3:0] repeat_cnt,
    input  logic       abort,
    output logic       y,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output state_e     dbg_state
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic          cnt_clear, cnt_step;
    logic [IW-1:0] bit_idx;
    logic [IW-1:0] code_idx;
    logic          last_bit, last_frame;

    sequence_tx_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (cnt_clear),
        .load_i       (repeat_cnt),
        .step_i       (cnt_step),
        .bit_idx_o    (bit_idx),
        .last_bit_o   (last_bit),
        .last_frame_o (last_frame)
    );

    // Next-state and counter control.
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = SEND;
                    cnt_clear = 1'b1;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (en) begin
                    cnt_step = 1'b1;
                    if (last_bit && last_frame) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode from state and bit pointer.
    always_comb begin
        code_idx = LAST_IDX - bit_idx;
        y        = 1'b0;
        valid    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            SEND: begin
                y     = CODE[code_idx];
                valid = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                y = 1'b0;
            end
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_sequence_tx.sv
// Self-checking bench for sequence_tx against a burst-level queue model.
module tb_sequence_tx;
    import sequence_tx_pkg::*;

    localparam int         W    = 5;
    localparam logic [4:0] CODE = 5'b10110;

    // Clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       en = 1'b0;
    logic       start = 1'b0;
    logic [3:0] repeat_cnt = 4'd0;
    logic       abort = 1'b0;
    logic       y, valid, busy, done;
    state_e     dbg_state;

    sequence_tx dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .start      (start),
        .repeat_cnt (repeat_cnt),
        .abort      (abort),
        .y          (y),
        .valid      (valid),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // Scoreboard / reference model: remaining bits of the burst
    logic       exp_q[$];
    logic       m_active = 1'b0;
    logic       m_done   = 1'b0;
    int         tests = 0;
    int         fails = 0;
    int         done_count = 0;
    int         strobes = 0;

    // Loopback detector model
    logic [W-1:0] det_sr = '0;
    int           det_fill = 0;
    int           det_count = 0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic ey;
        ey = (m_active && exp_q.size() > 0) ? exp_q[0] : 1'b0;
        chk({tag, ".y"},     y,     ey);
        chk({tag, ".valid"}, valid, m_active);
        chk({tag, ".busy"},  busy,  m_active | m_done);
        chk({tag, ".done"},  done,  m_done);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_active = 1'b0;
        m_done   = 1'b0;
    endtask

    // Driver: apply inputs, advance one edge, update model, check outputs
    task automatic cycle(input logic s, input logic e, input logic a,
                         input logic [3:0] rc, input string tag);
        start = s; en = e; abort = a; repeat_cnt = rc;
        // loopback detector consumes y on the same en strobe
        if (e && valid) begin
            det_sr = {det_sr[W-2:0], y};
            det_fill++;
            if (det_fill >= W && det_sr == CODE) det_count++;
        end
        @(posedge clk);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_active) begin
            if (a) begin
                model_reset();
            end else if (e) begin
                void'(exp_q.pop_front());
                strobes++;
                if (exp_q.size() == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (s && !a) begin
            for (int f = 0; f <= int'(rc); f++)
                for (int b = W - 1; b >= 0; b--)
                    exp_q.push_back(CODE[b]);
            m_active = 1'b1;
            strobes  = 0;
        end
        #1;
        if (done) done_count++;
        check_outputs(tag);
    endtask

    initial begin
        // Reset held: toggling inputs has no effect
        #1;
        for (int i = 0; i < 4; i++) begin
            start = i[0]; en = ~i[0];
            @(posedge clk); #1;
            check_outputs("rst_hold");
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 4'd0, "rst_rel");
        chk("rst_idle_state", dbg_state == IDLE, 1'b1);

        // Single frame, en every cycle: 1,0,1,1,0 then done then idle
        cycle(1'b1, 1'b1, 1'b0, 4'd0, "single");
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 4'd0, "single");
        chk_int("single_done_pulses", done_count, 1);

        // Sparse strobes, two frames; start accepted without en
        cycle(1'b1, 1'b0, 1'b0, 4'd1, "sparse");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 4'd1, "sparse");
            cycle(1'b0, 1'b0, 1'b0, 4'd1, "sparse");
            cycle(1'b0, 1'b1, 1'b0, 4'd1, "sparse");
        end
        chk_int("sparse_strobes", strobes, 2 * W);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, "sparse");
        chk_int("sparse_done_pulses", done_count, 2);

        // Abort after the 2nd bit, then restart from bit 1
        cycle(1'b1, 1'b1, 1'b0, 4'd3, "abort");
        cycle(1'b0, 1'b1, 1'b0, 4'd3, "abort");
        cycle(1'b0, 1'b1, 1'b0, 4'd3, "abort");
        cycle(1'b0, 1'b1, 1'b1, 4'd3, "abort");
        cycle(1'b1, 1'b1, 1'b1, 4'd0, "abort_prio");
        cycle(1'b1, 1'b1, 1'b0, 4'd0, "restart");
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 4'd0, "restart");
        chk_int("abort_done_pulses", done_count, 3);

        // Start pulses while busy with a different repeat_cnt are ignored
        cycle(1'b1, 1'b1, 1'b0, 4'd1, "ign_start");
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, 4'd7, "ign_start");
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 4'd7, "ign_start");
        chk_int("ign_done_pulses", done_count, 4);

        // Loopback into detector model, three frames
        det_sr = '0; det_fill = 0; det_count = 0;
        cycle(1'b1, 1'b1, 1'b0, 4'd2, "loop");
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 1'b0, 4'd2, "loop");
        chk_int("loop_det_count", det_count, 3);

        // Asynchronous reset mid-burst discards the burst
        cycle(1'b1, 1'b1, 1'b0, 4'd4, "mid_rst");
        cycle(1'b0, 1'b1, 1'b0, 4'd4, "mid_rst");
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst_async");
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 4'd4, "mid_rst_idle");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 40) == 0), 4'($urandom_range(0, 3)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
